// File: rtl/pll_reset_sequencer_if.sv
// ============================================================================
// Module  : pll_reset_sequencer_if
// Brief   : Lock input, clear and reset/status outputs of the PLL reset
//           sequencer. The o_loss_count member exists only with LOCK_LOSS_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pll_reset_sequencer_if;
    logic       i_pll_locked;
    logic       i_clear;
    logic       o_rst;
    logic       o_ready;
    logic       o_lock_lost;
    logic [1:0] o_state;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] o_loss_count;
`endif

    modport master (
        output i_pll_locked,
        output i_clear,
        input  o_rst,
        input  o_ready,
        input  o_lock_lost,
`ifdef LOCK_LOSS_CNT_EN
        input  o_loss_count,
`endif
        input  o_state
    );

    modport slave (
        input  i_pll_locked,
        input  i_clear,
        output o_rst,
        output o_ready,
        output o_lock_lost,
`ifdef LOCK_LOSS_CNT_EN
        output o_loss_count,
`endif
        output o_state
    );
endinterface

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module  : pll_reset_sequencer
// Brief   : Synchronizes PLL LOCK, holds the PLL domain in reset until lock has
//           been stable for STABLE_CYCLES, and re-asserts it for at least
//           FAULT_CYCLES on any lock loss. Optional macro LOCK_LOSS_CNT_EN adds
//           a saturating lock-loss counter (o_loss_count).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned FAULT_CYCLES  = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    pll_reset_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_fault_last  = CNT_W'(FAULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_WAIT   = 2'b00,
        S_STABLE = 2'b01,
        S_FAULT  = 2'b10,
        S_RUN    = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_rst;
    logic                   r_ready;
    logic                   r_lock_lost;
    logic                   w_lock_s;
    logic                   w_loss_event;

    // LOCK is asynchronous to i_clk; only the last stage is ever observed.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_pll_locked};
        end
    end

    assign w_lock_s     = r_sync[SYNC_STAGES-1];
    assign w_loss_event = (r_state == S_RUN) && !w_lock_s;

    // o_rst/o_ready are decoded from the state being entered, so they move on
    // the same edge as r_state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_WAIT;
            r_cnt       <= '0;
            r_rst       <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_rst   <= 1'b1;
            r_ready <= 1'b0;

            if (w_loss_event) begin
                r_lock_lost <= 1'b1;
            end else if (bus.i_clear) begin
                r_lock_lost <= 1'b0;
            end

            case (r_state)
                S_WAIT: begin
                    if (w_lock_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_stable_last) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_rst   <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_RUN: begin
                    if (!w_lock_s) begin
                        r_state <= S_FAULT;
                        r_cnt   <= '0;
                    end else begin
                        r_rst   <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                S_FAULT: begin
                    // Lock coming back early must not shorten the fault pulse.
                    if (r_cnt == c_fault_last) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.o_rst       = r_rst;
    assign bus.o_ready     = r_ready;
    assign bus.o_lock_lost = r_lock_lost;
    assign bus.o_state     = r_state;

`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] r_loss_count;

    // A clear coinciding with a loss leaves exactly that one loss counted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_loss_count <= 8'd0;
        end else if (bus.i_clear) begin
            r_loss_count <= w_loss_event ? 8'd1 : 8'd0;
        end else if (w_loss_event && (r_loss_count != 8'hFF)) begin
            r_loss_count <= r_loss_count + 8'd1;
        end
    end

    assign bus.o_loss_count = r_loss_count;
`endif

endmodule

`default_nettype wire
